// File: rtl/cpu_pkg.sv
// Shared CPU definitions: shift/rotate op encodings (also used by the ALU
// decode) and the shift unit's FSM state encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRor = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } shift_state_e;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AmtWidth  = 5;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step (combinational).
// Ports:
//   op        - operation (SLL, SRL, SRA, ROR)
//   value_in  - 32-bit operand
//   value_out - operand moved by exactly one bit position
module shift_step
  import cpu_pkg::*;
(
  input  shift_op_e              op,
  input  logic [DataWidth-1:0]   value_in,
  output logic [DataWidth-1:0]   value_out
);

  always_comb begin
    value_out = value_in;
    unique case (op)
      OpSll:   value_out = {value_in[DataWidth-2:0], 1'b0};
      OpSrl:   value_out = {1'b0, value_in[DataWidth-1:1]};
      OpSra:   value_out = {value_in[DataWidth-1], value_in[DataWidth-1:1]};
      OpRor:   value_out = {value_in[0], value_in[DataWidth-1:1]};
      default: value_out = value_in;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Sequential shift unit: one bit per cycle using a single shift_step.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   start    - request; accepted only while idle
//   op       - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data     - operand, amt - shift amount 0..31
//   busy     - high in SHIFT and DONE
//   done     - one-cycle result-valid pulse
//   result   - shifted value, held until the next completion
module shift_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  shift_state_e          state_q;
  shift_op_e             op_q;
  logic [DataWidth-1:0]  work_q;
  logic [AmtWidth-1:0]   cnt_q;
  logic [DataWidth-1:0]  step_out;

  shift_step u_shift_step (
    .op        (op_q),
    .value_in  (work_q),
    .value_out (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpSll;
      work_q  <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= shift_op_e'(op);
            work_q <= data;
            cnt_q  <= amt;
            busy   <= 1'b1;
            if (amt == '0) begin
              // Nothing to shift: result is the operand itself.
              state_q <= StDone;
              done    <= 1'b1;
              result  <= data;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          work_q <= step_out;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == AmtWidth'(1)) begin
            // Last step: publish the value being shifted in this edge.
            state_q <= StDone;
            done    <= 1'b1;
            result  <= step_out;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data;
  logic [4:0]  amt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total;
  int bad;

  shift_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .data   (data),
    .amt    (amt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one request at a negedge, scramble inputs after acceptance, then
  // measure latency to done and check the held result.
  task automatic run_vec(input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; op = v.op; data = v.data; amt = v.amt;
    @(negedge clk);
    start = 1'b0; op = ~v.op; data = ~v.data; amt = ~v.amt;
    check({v.name, " busy"}, {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check({v.name, " latency"}, lat, int'(v.amt) + 1);
    check({v.name, " result"}, result, v.exp);
    @(negedge clk);
    check({v.name, " done drop"}, {31'b0, done}, 32'd0);
    check({v.name, " busy drop"}, {31'b0, busy}, 32'd0);
    check({v.name, " result hold"}, result, v.exp);
  endtask

  initial begin
    int lat;
    int pulses;
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; data = '0; amt = '0;

    vecs[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31"};
    vecs[1]  = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, "sra4"};
    vecs[2]  = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, "srl4"};
    vecs[3]  = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, "ror1"};
    vecs[4]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, "amt0"};
    vecs[5]  = '{2'b00, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F00, "sll4"};
    vecs[6]  = '{2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, "ror8"};
    vecs[7]  = '{2'b10, 32'h7000_0000, 5'd31, 32'h0000_0000, "sra31pos"};
    vecs[8]  = '{2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, "sra31neg"};
    vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, "srl31"};
    vecs[10] = '{2'b11, 32'h8000_0000, 5'd31, 32'h0000_0001, "ror31"};

    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    // start during reset must not be accepted
    start = 1'b1; op = 2'b00; data = 32'hFFFF_FFFF; amt = 5'd0;
    @(negedge clk);
    check("start in reset busy", {31'b0, busy}, 32'd0);
    check("start in reset result", result, 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Start pulsed mid-SHIFT and again in DONE: both ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; data = 32'h0000_0001; amt = 5'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b11; data = 32'hDEAD_BEEF; amt = 5'd0;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    for (int k = 3; k <= 40; k++) begin
      lat = k;
      if (done) break;
      @(negedge clk);
    end
    check("ignore latency", lat, 6);
    check("ignore result", result, 32'h0000_0020);
    start = 1'b1; op = 2'b01; data = 32'hAAAA_AAAA; amt = 5'd3;
    @(negedge clk);
    check("start in done busy", {31'b0, busy}, 32'd0);
    check("start in done result", result, 32'h0000_0020);
    start = 1'b0;

    // Reset during SHIFT cycle 3 of an amt=10 request.
    @(negedge clk);
    start = 1'b1; op = 2'b00; data = 32'h0000_0001; amt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'd0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("abort no done", pulses, 0);

    // Unit still works after abort.
    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: start  input  1  request to begin a shift; sampled on rising edge.
REQ-004 SHALL have port: op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-005 SHALL have port: data  input  32  operand to shift; this is the operand-select stage output.
REQ-006 SHALL have port: amt  input  5  shift amount, 0..31.
REQ-007 SHALL have port: busy  output  1  high while a request is in progress (states SHIFT and DONE).
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL have port: result  output  32  shifted value, held until the next accepted request.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-011 SHALL accept a request only on an edge where state=IDLE and start=1; on acceptance it latches op, data into the working register and amt into a 5-bit counter.
REQ-012 SHALL transition to DONE on acceptance if amt=0, else to SHIFT.
REQ-013 SHALL, on each SHIFT edge, shift the working register by one bit per op and decrement the counter.
REQ-014 SHALL, on the SHIFT edge where counter=1, transition to DONE.
REQ-015 SHALL perform single-bit steps as follows: SLL fills 0 at bit 0; SRL fills 0 at bit 31; SRA replicates bit 31; ROR moves bit 0 to bit 31.
REQ-016 SHALL assert done and drive result from the working register for exactly one cycle in DONE, then return to IDLE on the next edge.
REQ-017 SHALL have latency: done high during cycle amt+1 after the accepting edge (amt=0 gives 1 cycle; amt=31 gives 32 cycles).
REQ-018 SHALL ignore start while busy=1, including in DONE, with no queueing and no effect on the in-flight operation.
REQ-019 SHALL ignore changes on op, data or amt after acceptance.
REQ-020 SHALL keep result stable in IDLE at the last completed value.
REQ-021 SHALL deassert busy in IDLE only; busy=0 and start=1 in the same cycle means acceptance at that edge.

Reset
REQ-022 SHALL, on rst=1 at an edge, set state=IDLE, busy=0, done=0, result=0x0000_0000, and clear the counter and working register.
REQ-023 SHALL give rst priority over start; any operation in progress when rst is asserted is abandoned and produces no done pulse.
REQ-024 SHALL produce no request acceptance in a cycle where rst=1.

Structure
REQ-025 SHALL take op encodings (SLL/SRL/SRA/ROR) and the state encoding from a shared package, cpu_pkg, which the ALU decode also uses.
REQ-026 SHALL implement the one-bit step as a combinational sub-module, shift_step (inputs op and 32-bit value; output 32-bit value), instantiated once.
REQ-027 SHALL use no multi-bit barrel logic; the datapath is one register, one counter and shift_step.

Verification
REQ-028 SHALL cover: SLL, data=0x0000_0001, amt=31 -> done after 32 cycles, result=0x8000_0000.
REQ-029 SHALL cover: SRA, data=0x8000_0000, amt=4 -> done after 5 cycles, result=0xF800_0000; repeated with SRL -> result=0x0800_0000.
REQ-030 SHALL cover: ROR, data=0x0000_0001, amt=1 -> result=0x8000_0000; amt=0 with data=0x1234_5678 -> done next cycle, result=0x1234_5678.
REQ-031 SHALL cover: start pulsed mid-SHIFT with different data -> ignored, original result and done timing unchanged.
REQ-032 SHALL cover: rst asserted at SHIFT cycle 3 of an amt=10 request -> next cycle busy=0, done=0, result=0, and no done pulse follows.
